fetch_unit: RTL and testbench

- Instruction-fetch stage for the basic 8-bit processor.
- Owns the program counter, drives the instruction ROM address, and registers the returned word into an instruction register (IR).
- Presents the IR to the downstream decode/sequencer with a valid/ready handshake.
- Accepts branch redirects and a halt request from the sequencer.

---
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers ROM words into the IR and
// hands them to decode over a valid/ready link, with branch redirect and halt.
module fetch_unit #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
) (
  input  logic                     clock,
  input  logic                     n_reset,
  output logic [WORD_W-OP_W-1:0]   Iaddress,
  input  logic [WORD_W-1:0]        Idata,
  input  logic                     run,
  output logic [WORD_W-1:0]        ir,
  output logic [OP_W-1:0]          opcode,
  output logic [WORD_W-OP_W-1:0]   operand,
  output logic [WORD_W-OP_W-1:0]   ir_pc,
  output logic                     ir_valid,
  input  logic                     ir_ready,
  input  logic                     br_valid,
  input  logic [WORD_W-OP_W-1:0]   br_target,
  input  logic                     halt_req,
  output logic                     halted,
  output logic [1:0]               dbg_state
);

  localparam int ADDR_W = WORD_W - OP_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, ir_pc_nxt;
  logic [WORD_W-1:0] ir_nxt;
  logic              ir_valid_nxt;
  logic              slot_free;

  // Handshake: a word transfers on a cycle where ir_valid=1 and ir_ready=1;
  // while ir_valid=1 and ir_ready=0 the IR and ir_pc are held unchanged.
  assign slot_free = !ir_valid || ir_ready;

  assign Iaddress  = pc;
  assign opcode    = ir[WORD_W-1 -: OP_W];
  assign operand   = ir[ADDR_W-1:0];
  assign halted    = (state == HALTED);
  assign dbg_state = state;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state    <= IDLE;
      pc       <= '0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      ir       <= ir_nxt;
      ir_pc    <= ir_pc_nxt;
      ir_valid <= ir_valid_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    ir_nxt       = ir;
    ir_pc_nxt    = ir_pc;
    ir_valid_nxt = ir_valid;
    case (state)
      IDLE: begin
        if (halt_req) begin
          state_nxt    = HALTED;
          ir_valid_nxt = 1'b0;
        end else if (br_valid) begin
          // Sets the start address; any held word is from the old path.
          pc_nxt       = br_target;
          ir_valid_nxt = 1'b0;
        end else begin
          if (ir_valid && ir_ready) ir_valid_nxt = 1'b0;
          if (run) state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (halt_req) begin
          state_nxt    = HALTED;
          ir_valid_nxt = 1'b0;
        end else if (br_valid) begin
          pc_nxt       = br_target;
          ir_valid_nxt = 1'b0;
          if (!run) state_nxt = IDLE;
        end else if (!run) begin
          state_nxt = IDLE;
          if (ir_valid && ir_ready) ir_valid_nxt = 1'b0;
        end else if (slot_free) begin
          ir_nxt       = Idata;
          ir_pc_nxt    = pc;
          ir_valid_nxt = 1'b1;
          pc_nxt       = pc + ADDR_W'(1);
        end
      end
      HALTED: begin
        ir_valid_nxt = 1'b0;
      end
      default: begin
        state_nxt    = IDLE;
        ir_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against a behavioural model
// of the fetch stage (PC, IR slot and run/idle/halt mode).
module tb_fetch_unit;
  localparam int WORD_W = 8;
  localparam int OP_W   = 3;
  localparam int ADDR_W = WORD_W - OP_W;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              n_reset;
  logic [ADDR_W-1:0] Iaddress;
  logic [WORD_W-1:0] Idata;
  logic              run;
  logic [WORD_W-1:0] ir;
  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              ir_ready;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;
  logic              halt_req;
  logic              halted;
  logic [1:0]        dbg_state;

  logic [WORD_W-1:0] rom [DEPTH];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  assign Idata = rom[Iaddress];

  fetch_unit #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
    .clock(clock), .n_reset(n_reset), .Iaddress(Iaddress), .Idata(Idata),
    .run(run), .ir(ir), .opcode(opcode), .operand(operand), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .br_valid(br_valid),
    .br_target(br_target), .halt_req(halt_req), .halted(halted),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [WORD_W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 = idle, 1 = fetching, 2 = halted
  int m_mode, m_pc, m_ir, m_ir_pc;
  bit m_valid;

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_ir = 0; m_ir_pc = 0; m_valid = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    if (m_mode == 2) return;
    if (halt_req) begin
      m_mode = 2; m_valid = 0; exp_q.delete();
      return;
    end
    if (br_valid) begin
      m_pc = int'(br_target); m_valid = 0; exp_q.delete();
      if (m_mode == 1 && !run) m_mode = 0;
      return;
    end
    if (m_mode == 0 || !run) begin
      if (m_valid && ir_ready) m_valid = 0;
      m_mode = run ? 1 : 0;
      return;
    end
    if (!m_valid || ir_ready) begin
      m_ir    = int'(rom[m_pc]);
      m_ir_pc = m_pc;
      m_valid = 1;
      m_pc    = (m_pc + 1) % DEPTH;
      exp_q.push_back(rom[m_ir_pc]);
    end
  endtask

  task automatic compare_all();
    check_eq("iaddress", Iaddress, m_pc);
    check_eq("ir_valid", ir_valid, m_valid);
    check_eq("halted",   halted,   m_mode == 2);
    check_eq("ir",       ir,       m_ir);
    check_eq("ir_pc",    ir_pc,    m_ir_pc);
    check_eq("opcode",   opcode,   m_ir / (1 << ADDR_W));
    check_eq("operand",  operand,  m_ir % (1 << ADDR_W));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    if (m_mode != 2 && m_valid && ir_ready && exp_q.size() > 0)
      check_eq("consume", ir, exp_q.pop_front());
    model_step();
    @(posedge clock); #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    run = 0; ir_ready = 0; br_valid = 0; br_target = '0; halt_req = 0;
  endtask

  task automatic do_reset();
    n_reset = 0;
    idle_inputs();
    model_reset();
    @(posedge clock); #1;
    compare_all();
    @(posedge clock); #1;
    n_reset = 1;
  endtask

  // Run fetching until the model PC reaches target, bounded.
  task automatic run_until_pc(input int target);
    int n = 0;
    run = 1; ir_ready = 1;
    while (m_pc != target && n < 64) begin tick(); n++; end
    check_eq("run_until_pc", m_pc, target);
  endtask

  int seq[4];

  initial begin
    for (int a = 0; a < DEPTH; a++) rom[a] = 8'hA0 + 8'(a);
    idle_inputs();
    n_reset = 0;
    model_reset();
    #2;
    // async reset state before any clock
    compare_all();
    do_reset();

    // 1: streaming fetch from reset
    run = 1; ir_ready = 1;
    tick();
    check_eq("t1_first_cycle_valid", ir_valid, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t1_ir_pc", ir_pc, i);
      check_eq("t1_ir", ir, 8'hA0 + i);
      check_eq("t1_lead", Iaddress, (i + 1) % DEPTH);
    end

    // 2: backpressure holding ROM[4]
    ir_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t2_hold_ir", ir, 8'hA4);
      check_eq("t2_hold_pc", ir_pc, 4);
      check_eq("t2_hold_iaddr", Iaddress, 5);
      check_eq("t2_hold_valid", ir_valid, 1);
    end
    ir_ready = 1;
    tick();
    check_eq("t2_next_pc", ir_pc, 5);
    check_eq("t2_next_ir", ir, 8'hA5);

    // 3: branch while ir_pc=10 is consumed
    run_until_pc(11);
    check_eq("t3_pre_pc", ir_pc, 10);
    br_valid = 1; br_target = 5'd4;
    tick();
    br_valid = 0;
    check_eq("t3_bubble", ir_valid, 0);
    tick();
    check_eq("t3_target_valid", ir_valid, 1);
    check_eq("t3_target_pc", ir_pc, 4);
    check_eq("t3_target_ir", ir, 8'hA4);

    // 4: start address 30 from IDLE, then wrap
    run = 0; tick(); tick();
    br_valid = 1; br_target = 5'd30; tick();
    br_valid = 0; run = 1; tick();
    for (int i = 0; i < 4; i++) begin tick(); seq[i] = int'(ir_pc); end
    check_eq("t4_seq0", seq[0], 30);
    check_eq("t4_seq1", seq[1], 31);
    check_eq("t4_seq2", seq[2], 0);
    check_eq("t4_seq3", seq[3], 1);

    // 5: halt beats a simultaneous branch
    do_reset();
    run_until_pc(6);
    halt_req = 1; br_valid = 1; br_target = 5'd7;
    tick();
    halt_req = 0; br_valid = 0;
    check_eq("t5_halted", halted, 1);
    check_eq("t5_valid", ir_valid, 0);
    check_eq("t5_pc", Iaddress, 6);
    for (int i = 0; i < 5; i++) begin
      run = 1; br_valid = i[0]; br_target = 5'($urandom_range(0, DEPTH - 1));
      ir_ready = 1'($urandom_range(0, 1));
      tick();
      check_eq("t5_frozen_pc", Iaddress, 6);
      check_eq("t5_still_halted", halted, 1);
    end
    br_valid = 0;

    // 6: async reset mid-stream
    do_reset();
    run_until_pc(9);
    check_eq("t6_pre_valid", ir_valid, 1);
    #2;
    n_reset = 0;
    model_reset();
    #1;
    check_eq("t6_async_valid", ir_valid, 0);
    check_eq("t6_async_iaddr", Iaddress, 0);
    check_eq("t6_async_ir", ir, 0);
    check_eq("t6_async_irpc", ir_pc, 0);
    @(negedge clock);
    n_reset = 1; run = 1; ir_ready = 1;
    tick(); tick();
    check_eq("t6_restart_pc", ir_pc, 0);
    check_eq("t6_restart_valid", ir_valid, 1);

    // 7: randomized traffic with a random ROM
    for (int a = 0; a < DEPTH; a++) rom[a] = 8'($urandom_range(0, 255));
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 150 == 149) do_reset();
      run       = ($urandom_range(0, 9) != 0);
      ir_ready  = 1'($urandom_range(0, 1));
      br_valid  = ($urandom_range(0, 9) == 0);
      br_target = 5'($urandom_range(0, DEPTH - 1));
      halt_req  = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1);
  end

endmodule
